// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and helpers for the RSA datapath
package rsa_pkg;

  typedef enum logic [1:0] {IDLE, ITER, FINAL} state_t;

  // Bit counter width for an operand of the given width
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/montgomery_step.sv
// rtl/montgomery_step.sv - one radix-2 Montgomery reduction step
// Forms r + a_bit*b + q*n at full width and halves it into the next residue.
module montgomery_step
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             q,
  output logic [WIDTH:0]   r_next
);

  logic [WIDTH+1:0] s;

  always_comb begin
    q      = r[0] ^ (a_bit & b[0]);
    // q makes the sum even, so the shift drops only a zero bit
    s      = {1'b0, r}
           + (a_bit ? {2'b00, b} : '0)
           + (q     ? {2'b00, n} : '0);
    r_next = s[WIDTH+1:1];
  end

endmodule

// File: rtl/montgomery_iter.sv
// rtl/montgomery_iter.sv - bit-serial Montgomery multiplier, R = A*B*2^-WIDTH mod N
// One bit of A per clock, then a single conditional subtraction.
module montgomery_iter
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int IW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH:0]   r;
  logic [IW-1:0]    i;
  logic             q;
  logic [WIDTH:0]   r_next;

  montgomery_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .a_bit  (a_reg[i]),
    .b      (b_reg),
    .n      (n_reg),
    .q      (q),
    .r_next (r_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      n_reg  <= '0;
      r      <= '0;
      i      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            n_reg <= n;
            r     <= '0;
            i     <= '0;
            busy  <= 1'b1;
            state <= ITER;
          end
        end
        ITER: begin
          r <= r_next;
          i <= i + 1'b1;
          if (i == IW'(WIDTH - 1)) state <= FINAL;
        end
        FINAL: begin
          // r < 2N holds here, so one subtraction fully reduces it
          result <= WIDTH'((r >= {1'b0, n_reg}) ? (r - {1'b0, n_reg}) : r);
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_iter.sv
// tb/tb_montgomery_iter.sv - self-checking bench for montgomery_iter
module tb_montgomery_iter;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] n;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int sb[$];

  montgomery_iter #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the unique k < N with k*2^8 == A*B (mod N)
  function automatic int ref_mont(input int av, input int bv, input int nv);
    int target;
    target = (av * bv) % nv;
    for (int k = 0; k < nv; k++)
      if (((k * 256) % nv) == target) return k;
    return -1;
  endfunction

  task automatic rand_ops(output logic [7:0] av, output logic [7:0] bv, output logic [7:0] nv);
    nv = 8'($urandom_range(3, 255) | 1);
    av = 8'($urandom_range(0, int'(nv) - 1));
    bv = 8'($urandom_range(0, int'(nv) - 1));
  endtask

  // Drives one operation and waits for done; lat=-1 on timeout
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] nv,
                        output logic [7:0] res, output int lat, output int busy_err);
    busy_err = 0;
    lat      = -1;
    res      = 'x;
    @(negedge clk);
    a = av; b = bv; n = nv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy !== 1'b1) busy_err++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (busy !== 1'b0) busy_err++;
        lat = k;
        res = result;
        break;
      end
      if (busy !== 1'b1) busy_err++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; n = '0;
    #12;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
    total_cnt++;
    if (result !== 8'd0) $display("FAIL reset_result got=%0d exp=0", result); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] res;
    int lat, berr, exp;
    sb.push_back(1);
    run_op(8'd5, 8'd7, 8'd13, res, lat, berr);
    exp = sb.pop_front();
    total_cnt++;
    if (lat !== 9) $display("FAIL basic_latency got=%0d exp=9", lat); else pass_cnt++;
    total_cnt++;
    if (berr !== 0) $display("FAIL basic_busy errors=%0d exp=0", berr); else pass_cnt++;
    total_cnt++;
    if (res !== 8'(exp)) $display("FAIL basic_result got=%0d exp=%0d", res, exp); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL basic_done_width got=%b exp=0", done); else pass_cnt++;
  endtask

  task automatic test_vectors();
    logic [7:0] ta [5] = '{8'd1, 8'd5, 8'd0, 8'd254, 8'd5};
    logic [7:0] tb [5] = '{8'd1, 8'd3, 8'd12, 8'd254, 8'd7};
    logic [7:0] tn [5] = '{8'd13, 8'd13, 8'd13, 8'd255, 8'd13};
    int         te [5] = '{3, 6, 0, 1, 1};
    logic [7:0] res;
    int lat, berr, exp;
    for (int v = 0; v < 5; v++) begin
      sb.push_back(te[v]);
      run_op(ta[v], tb[v], tn[v], res, lat, berr);
      exp = sb.pop_front();
      total_cnt++;
      if (res !== 8'(exp) || lat !== 9)
        $display("FAIL vector_%0d got=%0d lat=%0d exp=%0d lat=9", v, res, lat, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [7:0] av, bv, nv, res;
    int lat, berr, exp;
    for (int t = 0; t < 1000; t++) begin
      rand_ops(av, bv, nv);
      sb.push_back(ref_mont(int'(av), int'(bv), int'(nv)));
      run_op(av, bv, nv, res, lat, berr);
      exp = sb.pop_front();
      total_cnt++;
      if (res !== 8'(exp) || lat !== 9 || berr !== 0)
        $display("FAIL random a=%0d b=%0d n=%0d got=%0d lat=%0d berr=%0d exp=%0d",
                 av, bv, nv, res, lat, berr, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] av, bv, nv;
    int last, exp, ndone;
    last  = -1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rand_ops(av, bv, nv);
      a = av; b = bv; n = nv; start = 1'b1;
      if (k % 10 == 0) sb.push_back(ref_mont(int'(av), int'(bv), int'(nv)));
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        exp = (sb.size() > 0) ? sb.pop_front() : -1;
        total_cnt++;
        if (result !== 8'(exp)) $display("FAIL b2b_result k=%0d got=%0d exp=%0d", k, result, exp);
        else pass_cnt++;
        total_cnt++;
        if (k - last !== 10) $display("FAIL b2b_period k=%0d got=%0d exp=10", k, k - last);
        else pass_cnt++;
        last = k;
      end
    end
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (ndone !== 4) $display("FAIL b2b_count got=%0d exp=4", ndone); else pass_cnt++;
    sb.delete();
    repeat (12) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] res;
    int lat, berr, ndone;
    run_op(8'd5, 8'd7, 8'd13, res, lat, berr);
    @(negedge clk);
    a = 8'd9; b = 8'd11; n = 8'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL rstmid_done got=%b exp=0", done); else pass_cnt++;
    total_cnt++;
    if (result !== 8'd0) $display("FAIL rstmid_result got=%0d exp=0", result); else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    total_cnt++;
    if (ndone !== 0) $display("FAIL rstmid_no_done got=%0d exp=0", ndone); else pass_cnt++;
    sb.push_back(1);
    run_op(8'd5, 8'd7, 8'd13, res, lat, berr);
    total_cnt++;
    if (res !== 8'(sb.pop_front()) || lat !== 9)
      $display("FAIL rstmid_restart got=%0d lat=%0d exp=1 lat=9", res, lat);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    int exp, ndone, done_at;
    logic [7:0] got;
    sb.push_back(ref_mont(9, 4, 13));
    @(negedge clk);
    a = 8'd9; b = 8'd4; n = 8'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; done_at = -1; got = 'x;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      start = (k >= 3 && k <= 6);
      a = 8'(k * 37); b = 8'(k * 11); n = 8'(k * 2 + 3);
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        done_at = k;
        got = result;
      end
    end
    exp = sb.pop_front();
    total_cnt++;
    if (ndone !== 1 || done_at !== 9)
      $display("FAIL busy_start_done count=%0d at=%0d exp count=1 at=9", ndone, done_at);
    else pass_cnt++;
    total_cnt++;
    if (got !== 8'(exp)) $display("FAIL busy_start_result got=%0d exp=%0d", got, exp);
    else pass_cnt++;
    total_cnt++;
    if (result !== 8'(exp)) $display("FAIL busy_start_hold got=%0d exp=%0d", result, exp);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_start_while_busy();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/montgomery_iter.md
# montgomery_iter

Bit-serial Montgomery modular multiplier for the RSA datapath. Computes R = A·B·2^(-WIDTH) mod N, one bit of A per clock. Each step forms the un-shifted partial sum r + a_i·B + q_i·N and halves it into the running residue. The top-level modexp sequencer calls it for every square and multiply, handshaking through start/done.

## Interface
- WIDTH, 8, operand width in bits; minimum 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplier A; requires A < N.
- b  input  WIDTH  multiplicand B; requires B < N.
- n  input  WIDTH  modulus N; requires N odd and N ≥ 3.
- busy  output  1  high while an operation is in flight.
- done  output  1  single-cycle completion pulse.
- result  output  WIDTH  Montgomery product; holds until the next completion.

## Operation
- States: IDLE, ITER, FINAL.
- IDLE, start=1 at a clock edge:
  - latch a, b, n into internal registers;
  - clear residue r (WIDTH+1 bits) and bit counter i;
  - go to ITER.
- IDLE, start=0: hold all registers.
- ITER, each edge:
  - take a_i = a_reg[i], LSB first;
  - q = r[0] XOR (a_i AND b_reg[0]);
  - s = r + (a_i ? b_reg : 0) + (q ? n_reg : 0), computed at WIDTH+2 bits, no truncation;
  - r <= s >> 1; i <= i + 1;
  - after the edge where i = WIDTH-1, go to FINAL.
- FINAL, one edge:
  - result <= (r ≥ n_reg) ? r − n_reg : r, truncated to WIDTH bits;
  - done <= 1; go to IDLE.
- Invariant: r < 2N after every step, so one conditional subtraction suffices.
- start is ignored in ITER and FINAL; there is no queueing.
- Inputs a, b, n may change freely after the start edge without affecting the operation.
- Behaviour is undefined for operands that violate the stated constraints. No error flag.
- Reset values: state IDLE; r, i, the latched operands and result all 0; busy 0; done 0.
- Reset is asynchronous and active-high. Asserting it mid-operation aborts immediately, returns everything to reset values and produces no done pulse.

## Timing
- Edge E0 samples start.
- Edges E1..E(WIDTH) execute the iterations.
- Edge E(WIDTH+1) executes FINAL.
- done is high for exactly one cycle after E(WIDTH+1), with result valid in that same cycle.
- Latency is WIDTH+1 cycles from the start-sampling edge to done.
- busy is registered: high after E0, low after E(WIDTH+1). busy and done are never both high.
- Back-to-back: start may be high in the done cycle; it is sampled at the next edge, since state is already IDLE.
- Throughput: one product per WIDTH+2 cycles.

## Structure
- rsa_pkg holds the state enum typedef (IDLE/ITER/FINAL) and the counter-width helper, $clog2(WIDTH).
- One combinational sub-module, montgomery_step, computes q and the (WIDTH+1)-bit next residue from r, a_i, b and n. It is reused by any future multi-bit-per-cycle variant.
- FSM, counter, operand registers and final subtraction live in montgomery_iter.

## Test plan
- WIDTH=8, N=13, A=5, B=7, start pulsed once → done exactly 9 cycles after the start edge, result=1; busy high for the 9 cycles before done.
- N=13, A=1, B=1 → result=3 (2^(-8) mod 13). N=13, A=5, B=3 (R² mod N) → result=6. N=13, A=0, B=12 → result=0.
- N=255, A=254, B=254 → result=1, exercising the WIDTH+2-bit sum without overflow. Run ≥1000 random odd N with A, B < N against a reference model of A·B·2^(-8) mod N.
- Start held high continuously; a, b, n changed on every cycle while busy → each result matches the operands captured at its own start edge; done pulses one cycle wide, periodic every 10 cycles.
- rst asserted asynchronously at iteration 4 → busy, done and result go to 0 without waiting for a clock edge, with no done pulse. After rst is released, a fresh start with N=13, A=5, B=7 gives result=1.
- Start asserted while busy, between the E0 and E(WIDTH+1) edges → ignored: no extra done, and the result is unchanged.
